// File: rtl/mem_fabric_pkg.sv
// Shared definitions for the data-side memory region fabric and its decoder.
package mem_fabric_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned TAG_W  = 16;
   localparam int unsigned WAIT_W = 3;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   localparam logic [TAG_W-1:0] TAG_DATA   = 16'h1000;
   localparam logic [TAG_W-1:0] TAG_STACK  = 16'h7fff;
   localparam logic [TAG_W-1:0] TAG_SERIAL = 16'hffff;

   // True when the access size is reserved or the address is not naturally aligned
   function automatic logic bad_size_align(input logic [1:0] size, input logic [1:0] low);
      return (size == SZ_RSVD) ||
             ((size == SZ_HALF) && low[0]) ||
             ((size == SZ_WORD) && (low != 2'b00));
   endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address/size decoder: tag match to one-hot select, wait value and fault flag.
module mem_region_decode
   import mem_fabric_pkg::*;
#(
   parameter int unsigned                  NUM_REGIONS = 3,
   parameter logic [NUM_REGIONS*16-1:0]    REGION_TAGS = {TAG_SERIAL, TAG_STACK, TAG_DATA},
   parameter logic [NUM_REGIONS*3-1:0]     REGION_WAIT = {3'd2, 3'd0, 3'd0},
   localparam int unsigned                 IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
   input  logic [ADDR_W-1:0]      addr,
   input  logic [1:0]             size,
   output logic [NUM_REGIONS-1:0] sel,
   output logic [IDX_W-1:0]       idx,
   output logic [WAIT_W-1:0]      wait_cycles,
   output logic                   fault
);

   logic hit;
   logic unused_addr_mid;

   assign unused_addr_mid = ^addr[15:2];

   // Scan from the top index down so the lowest matching index wins on duplicate tags
   always_comb begin
      hit         = 1'b0;
      idx         = '0;
      wait_cycles = '0;
      sel         = '0;
      for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
         if (addr[31:16] == REGION_TAGS[i*16 +: 16]) begin
            hit         = 1'b1;
            idx         = IDX_W'(i);
            wait_cycles = REGION_WAIT[i*3 +: 3];
         end
      end
      if (hit) begin
         sel = NUM_REGIONS'(1) << idx;
      end
      fault = !hit || bad_size_align(size, addr[1:0]);
   end

endmodule

// File: rtl/mem_region_fabric.sv
// Data-side region fabric: accepts one request, drives the selected target for
// WAIT+1 cycles, returns a one-cycle registered response and tracks faults.
module mem_region_fabric
   import mem_fabric_pkg::*;
#(
   parameter int unsigned               NUM_REGIONS = 3,
   parameter logic [NUM_REGIONS*16-1:0] REGION_TAGS = {TAG_SERIAL, TAG_STACK, TAG_DATA},
   parameter logic [NUM_REGIONS*3-1:0]  REGION_WAIT = {3'd2, 3'd0, 3'd0},
   parameter int unsigned               FAULT_CNT_W = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        req_valid_in,
   output logic                        req_ready_out,
   input  logic [ADDR_W-1:0]           addr_in,
   input  logic [DATA_W-1:0]           writedata_in,
   input  logic                        we_in,
   input  logic [1:0]                  size_in,
   output logic                        resp_valid_out,
   output logic [DATA_W-1:0]           resp_data_out,
   output logic                        resp_err_out,
   output logic [NUM_REGIONS-1:0]      region_sel_out,
   output logic                        region_re_out,
   output logic                        region_we_out,
   output logic [ADDR_W-1:0]           region_addr_out,
   output logic [DATA_W-1:0]           region_wdata_out,
   output logic [1:0]                  region_size_out,
   input  logic [NUM_REGIONS*32-1:0]   region_rdata_in,
   output logic [FAULT_CNT_W-1:0]      fault_count_out,
   output logic [ADDR_W-1:0]           fault_addr_out
);

   localparam int unsigned IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   state_e                 state;
   logic [NUM_REGIONS-1:0] dec_sel;
   logic [IDX_W-1:0]       dec_idx;
   logic [WAIT_W-1:0]      dec_wait;
   logic                   dec_fault;
   logic [IDX_W-1:0]       idx_q;
   logic [WAIT_W-1:0]      wait_cnt;
   logic                   we_q;
   logic [DATA_W-1:0]      rdata_sel;

   mem_region_decode #(
      .NUM_REGIONS (NUM_REGIONS),
      .REGION_TAGS (REGION_TAGS),
      .REGION_WAIT (REGION_WAIT)
   ) u_decode (
      .addr        (addr_in),
      .size        (size_in),
      .sel         (dec_sel),
      .idx         (dec_idx),
      .wait_cycles (dec_wait),
      .fault       (dec_fault)
   );

   // Read-data mux for the region latched at acceptance
   always_comb begin
      rdata_sel = '0;
      for (int i = 0; i < int'(NUM_REGIONS); i++) begin
         if (idx_q == IDX_W'(i)) begin
            rdata_sel = region_rdata_in[i*32 +: 32];
         end
      end
   end

   // Request FSM with registered strobes, response and fault bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= ST_IDLE;
         req_ready_out    <= 1'b1;
         resp_valid_out   <= 1'b0;
         resp_data_out    <= '0;
         resp_err_out     <= 1'b0;
         region_sel_out   <= '0;
         region_re_out    <= 1'b0;
         region_we_out    <= 1'b0;
         region_addr_out  <= '0;
         region_wdata_out <= '0;
         region_size_out  <= '0;
         fault_count_out  <= '0;
         fault_addr_out   <= '0;
         idx_q            <= '0;
         wait_cnt         <= '0;
         we_q             <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_in) begin
                  region_addr_out  <= addr_in;
                  region_wdata_out <= writedata_in;
                  region_size_out  <= size_in;
                  we_q             <= we_in;
                  idx_q            <= dec_idx;
                  req_ready_out    <= 1'b0;
                  if (dec_fault) begin
                     state          <= ST_RESP;
                     resp_valid_out <= 1'b1;
                     resp_err_out   <= 1'b1;
                     resp_data_out  <= '0;
                     fault_addr_out <= addr_in;
                     if (fault_count_out != '1) begin
                        fault_count_out <= fault_count_out + FAULT_CNT_W'(1);
                     end
                  end else begin
                     state          <= ST_ACCESS;
                     wait_cnt       <= dec_wait;
                     region_sel_out <= dec_sel;
                     region_re_out  <= !we_in;
                     region_we_out  <= we_in && (dec_wait == '0);
                  end
               end
            end
            ST_ACCESS: begin
               if (wait_cnt != '0) begin
                  wait_cnt      <= wait_cnt - WAIT_W'(1);
                  region_we_out <= we_q && (wait_cnt == WAIT_W'(1));
               end else begin
                  state          <= ST_RESP;
                  region_sel_out <= '0;
                  region_re_out  <= 1'b0;
                  region_we_out  <= 1'b0;
                  resp_valid_out <= 1'b1;
                  resp_err_out   <= 1'b0;
                  resp_data_out  <= we_q ? '0 : rdata_sel;
               end
            end
            ST_RESP: begin
               state          <= ST_IDLE;
               resp_valid_out <= 1'b0;
               resp_err_out   <= 1'b0;
               resp_data_out  <= '0;
               req_ready_out  <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_region_fabric.sv
// Bench for mem_region_fabric: table-driven stream with a response scoreboard,
// plus hand-timed sequences for strobe timing, reset abort and counter saturation.
module tb_mem_region_fabric;

   localparam int unsigned NR = 3;
   localparam int unsigned CW = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              req_valid_in;
   logic              req_ready_out;
   logic [31:0]       addr_in;
   logic [31:0]       writedata_in;
   logic              we_in;
   logic [1:0]        size_in;
   logic              resp_valid_out;
   logic [31:0]       resp_data_out;
   logic              resp_err_out;
   logic [NR-1:0]     region_sel_out;
   logic              region_re_out;
   logic              region_we_out;
   logic [31:0]       region_addr_out;
   logic [31:0]       region_wdata_out;
   logic [1:0]        region_size_out;
   logic [NR*32-1:0]  region_rdata_in;
   logic [CW-1:0]     fault_count_out;
   logic [31:0]       fault_addr_out;

   mem_region_fabric #(
      .NUM_REGIONS (NR),
      .REGION_TAGS ({16'hffff, 16'h7fff, 16'h1000}),
      .REGION_WAIT ({3'd2, 3'd0, 3'd0}),
      .FAULT_CNT_W (CW)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid_in     (req_valid_in),
      .req_ready_out    (req_ready_out),
      .addr_in          (addr_in),
      .writedata_in     (writedata_in),
      .we_in            (we_in),
      .size_in          (size_in),
      .resp_valid_out   (resp_valid_out),
      .resp_data_out    (resp_data_out),
      .resp_err_out     (resp_err_out),
      .region_sel_out   (region_sel_out),
      .region_re_out    (region_re_out),
      .region_we_out    (region_we_out),
      .region_addr_out  (region_addr_out),
      .region_wdata_out (region_wdata_out),
      .region_size_out  (region_size_out),
      .region_rdata_in  (region_rdata_in),
      .fault_count_out  (fault_count_out),
      .fault_addr_out   (fault_addr_out)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [1:0]  size;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   resp_t sb[$];
   int    n_vec = 0;
   int    n_bad = 0;
   int    resp_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every response pulse must match the oldest outstanding expectation
   always @(negedge clock) begin
      if (!reset && resp_valid_out) begin
         resp_t e;
         resp_seen++;
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL resp_unexpected: got data 0x%08h err %0d, expected no response", resp_data_out, resp_err_out);
         end else begin
            e = sb.pop_front();
            check("resp_data", resp_data_out, e.data);
            check("resp_err", 32'(resp_err_out), 32'(e.err));
         end
      end
   end

   // Present a request, wait (bounded) for acceptance, log the expected response
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [1:0] s, input logic [31:0] ed, input logic ee);
      int n;
      resp_t r;
      n = 0;
      req_valid_in = 1'b1;
      addr_in      = a;
      writedata_in = d;
      we_in        = w;
      size_in      = s;
      while (!req_ready_out && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!req_ready_out) begin
         check("accept_timeout", 32'(req_ready_out), 32'd1);
         req_valid_in = 1'b0;
      end else begin
         r.data = ed;
         r.err  = ee;
         sb.push_back(r);
         @(posedge clock);
         #1;
         req_valid_in = 1'b0;
      end
   endtask

   // Wait (bounded) for every outstanding response, then settle back in IDLE
   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("drain_outstanding", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clock);
   endtask

   vec_t vecs[10];

   initial begin
      int seen0;
      resp_t r;

      vecs[0] = '{32'h1000_0004, 32'h0,         1'b0, 2'd2, 32'hDEAD_BEEF, 1'b0};
      vecs[1] = '{32'hFFFF_0001, 32'h0000_00A5, 1'b1, 2'd0, 32'h0,         1'b0};
      vecs[2] = '{32'h2000_0000, 32'h0,         1'b0, 2'd2, 32'h0,         1'b1};
      vecs[3] = '{32'h7FFF_0003, 32'h0,         1'b0, 2'd1, 32'h0,         1'b1};
      vecs[4] = '{32'h7FFF_0008, 32'h0,         1'b0, 2'd2, 32'h5555_AAAA, 1'b0};
      vecs[5] = '{32'hFFFF_0002, 32'h0,         1'b0, 2'd1, 32'h0000_00C3, 1'b0};
      vecs[6] = '{32'h1000_0000, 32'h0,         1'b0, 2'd3, 32'h0,         1'b1};
      vecs[7] = '{32'h1000_0002, 32'h0,         1'b0, 2'd2, 32'h0,         1'b1};
      vecs[8] = '{32'h1000_0002, 32'h0000_1234, 1'b1, 2'd1, 32'h0,         1'b0};
      vecs[9] = '{32'h7FFF_0003, 32'h0,         1'b0, 2'd0, 32'h5555_AAAA, 1'b0};

      region_rdata_in = {32'h0000_00C3, 32'h5555_AAAA, 32'hDEAD_BEEF};
      req_valid_in = 1'b0;
      addr_in      = '0;
      writedata_in = '0;
      we_in        = 1'b0;
      size_in      = '0;
      reset        = 1'b1;

      // Reset state
      #1;
      check("rst_ready", 32'(req_ready_out), 32'd1);
      check("rst_resp_valid", 32'(resp_valid_out), 32'd0);
      check("rst_sel", 32'(region_sel_out), 32'd0);
      check("rst_fault_count", 32'(fault_count_out), 32'd0);
      check("rst_fault_addr", fault_addr_out, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Word load to region 0, no wait: select/read for one cycle, response next
      issue(32'h1000_0004, 32'h0, 1'b0, 2'd2, 32'hDEAD_BEEF, 1'b0);
      @(negedge clock);
      check("ld_sel", 32'(region_sel_out), 32'b001);
      check("ld_re", 32'(region_re_out), 32'd1);
      check("ld_we", 32'(region_we_out), 32'd0);
      check("ld_ready_busy", 32'(req_ready_out), 32'd0);
      check("ld_no_resp_yet", 32'(resp_valid_out), 32'd0);
      check("ld_region_addr", region_addr_out, 32'h1000_0004);
      @(negedge clock);
      check("ld_resp_valid", 32'(resp_valid_out), 32'd1);
      check("ld_sel_off", 32'(region_sel_out), 32'd0);
      check("ld_re_off", 32'(region_re_out), 32'd0);
      drain();

      // Byte store to region 2, two wait states: one write strobe in the last access cycle
      issue(32'hFFFF_0001, 32'h0000_005A, 1'b1, 2'd0, 32'h0, 1'b0);
      @(negedge clock);
      check("st_c1_sel", 32'(region_sel_out), 32'b100);
      check("st_c1_re", 32'(region_re_out), 32'd0);
      check("st_c1_we", 32'(region_we_out), 32'd0);
      check("st_wdata", region_wdata_out, 32'h0000_005A);
      @(negedge clock);
      check("st_c2_sel", 32'(region_sel_out), 32'b100);
      check("st_c2_we", 32'(region_we_out), 32'd0);
      check("st_c2_ready", 32'(req_ready_out), 32'd0);
      @(negedge clock);
      check("st_c3_sel", 32'(region_sel_out), 32'b100);
      check("st_c3_we", 32'(region_we_out), 32'd1);
      check("st_c3_no_resp", 32'(resp_valid_out), 32'd0);
      @(negedge clock);
      check("st_resp_valid", 32'(resp_valid_out), 32'd1);
      check("st_we_off", 32'(region_we_out), 32'd0);
      drain();

      // Unmapped load: response one cycle after acceptance, no strobes
      issue(32'h2000_0000, 32'h0, 1'b0, 2'd2, 32'h0, 1'b1);
      @(negedge clock);
      check("flt_resp_valid", 32'(resp_valid_out), 32'd1);
      check("flt_sel", 32'(region_sel_out), 32'd0);
      check("flt_re", 32'(region_re_out), 32'd0);
      check("flt_count", 32'(fault_count_out), 32'd1);
      check("flt_addr", fault_addr_out, 32'h2000_0000);
      drain();

      // Table stream, requests held back-to-back; responses must arrive in order
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].size, vecs[i].exp_data, vecs[i].exp_err);
      end
      drain();
      check("tbl_fault_count", 32'(fault_count_out), 32'd5);
      check("tbl_fault_addr", fault_addr_out, 32'h1000_0002);
      check("tbl_region_size", 32'(region_size_out), 32'd0);

      // Reset mid-access on the slow region: strobes drop at once, no response
      seen0 = resp_seen;
      req_valid_in = 1'b1;
      addr_in      = 32'hFFFF_0000;
      we_in        = 1'b0;
      size_in      = 2'd2;
      @(posedge clock);
      #1;
      req_valid_in = 1'b0;
      @(negedge clock);
      check("rstmid_sel_before", 32'(region_sel_out), 32'b100);
      check("rstmid_re_before", 32'(region_re_out), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_sel_async", 32'(region_sel_out), 32'd0);
      check("rstmid_re_async", 32'(region_re_out), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("rstmid_ready", 32'(req_ready_out), 32'd1);
      check("rstmid_fault_count", 32'(fault_count_out), 32'd0);
      repeat (5) @(negedge clock);
      check("rstmid_no_resp", 32'(resp_seen - seen0), 32'd0);

      // Fault counter saturates at all-ones
      for (int i = 0; i < (1 << CW) + 1; i++) begin
         issue(32'h2000_0000 + 32'(i * 4), 32'h0, 1'b0, 2'd2, 32'h0, 1'b1);
      end
      drain();
      check("sat_fault_count", 32'(fault_count_out), 32'((1 << CW) - 1));
      check("sat_fault_addr", fault_addr_out, 32'h2000_0040);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/mem_region_fabric.md
Name: mem_region_fabric

Overview:
- Parametrised successor to the fixed three-region data-side decoder.
- Sits between the CPU load/store stage and up to NUM_REGIONS memory-mapped targets: data segment, stack segment, serial buffer, plus new peripherals.
- Adds a valid/ready request handshake, per-region programmable wait states, a registered response, and fault detection for unmapped, misaligned and bad-size accesses, with a saturating fault counter.

Parameters:
- NUM_REGIONS, 3, number of downstream targets (1..8).
- REGION_TAGS, {16'hffff,16'h7fff,16'h1000}, packed NUM_REGIONS*16 vector; region i is selected when addr[31:16] equals tag i.
- REGION_WAIT, {3'd2,3'd0,3'd0}, packed NUM_REGIONS*3 vector; extra wait cycles for region i (0..7).
- FAULT_CNT_W, 16, fault counter width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  fabric can accept a request (high only in IDLE).
- addr_in  input  32  byte address.
- writedata_in  input  32  store data.
- we_in  input  1  1 = store, 0 = load.
- size_in  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- resp_valid_out  output  1  one-cycle response pulse.
- resp_data_out  output  32  load data; 0 for stores and faults.
- resp_err_out  output  1  response is a fault.
- region_sel_out  output  NUM_REGIONS  one-hot target select.
- region_re_out  output  1  read strobe to the selected target.
- region_we_out  output  1  write strobe to the selected target.
- region_addr_out  output  32  registered address.
- region_wdata_out  output  32  registered store data.
- region_size_out  output  2  registered size.
- region_rdata_in  input  NUM_REGIONS*32  read data; slice i belongs to region i.
- fault_count_out  output  FAULT_CNT_W  saturating fault count.
- fault_addr_out  output  32  address of the most recent fault.

Behaviour:
- Reset: state = IDLE; every output 0 except req_ready_out = 1. Reset is asynchronous, so strobes drop immediately and any in-flight access is abandoned with no response.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready_out = 1.
  - On req_valid_in at a clock edge, register addr, wdata, we and size.
  - Decode in the same cycle.
  - Fault → RESP with err = 1. Otherwise load wait_cnt = REGION_WAIT[sel] and go to ACCESS.
- Faults:
  - No tag matches.
  - size = 3.
  - size = 1 with addr[0] = 1.
  - size = 2 with addr[1:0] != 0.
- Duplicate tags: the lowest index wins.
- ACCESS:
  - region_sel_out is one-hot and held for the whole state.
  - region_re_out = ~we for the whole state.
  - region_we_out = we only in the final ACCESS cycle (wait_cnt == 0), so each store produces exactly one write strobe.
  - While wait_cnt != 0: decrement it.
  - When wait_cnt == 0: capture the selected region_rdata_in slice into resp_data (forced to 0 for stores), then go to RESP.
- RESP:
  - resp_valid_out = 1 for exactly one cycle; there is no backpressure.
  - Sel and strobes are 0.
  - Next state is IDLE.
  - A new request can be accepted on the cycle after RESP.
- Latency, counted from the accepting edge to the resp_valid_out cycle:
  - Good access: WAIT + 2 cycles.
  - Fault: 1 cycle.
  - Throughput: one request per WAIT + 3 cycles.
- Fault bookkeeping: on entry to RESP with a fault, fault_count increments, saturating at all-ones, and fault_addr_out is loaded with the faulting address.
- A req_valid_in outside IDLE is ignored, because req_ready_out = 0.
- Region outputs (addr/wdata/size) hold their last value until the next acceptance.

Decomposition:
- Shared package mem_fabric_pkg:
  - Size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD.
  - FSM state encoding.
  - Default tag constants for the data, stack and serial segments.
- Sub-module mem_region_decode, purely combinational:
  - Inputs: addr, size.
  - Outputs: one-hot sel, region index, wait value, fault flag.
  - Reused by the future instruction-side fabric.

Test Plan:
- Word load at 0x10000004, region 0 data 0xDEADBEEF, WAIT = 0 → sel = 3'b001, re high 1 cycle; resp_valid 2 cycles after acceptance with data 0xDEADBEEF, err = 0.
- Byte store to 0xFFFF0001, region 2 WAIT = 2 → re = 0, sel = 3'b100 for 3 cycles, we high only in the 3rd; resp_valid 4 cycles after acceptance, data 0.
- Loads to 0x20000000 and a half load to 0x7FFF0003 → each gives resp 1 cycle after acceptance with err = 1, no strobes; fault_count = 2, fault_addr = 0x7FFF0003.
- Back-to-back requests with req_valid_in held high → req_ready_out low in ACCESS/RESP; second request accepted only in IDLE; both responses correct and in order.
- Reset asserted mid-ACCESS with WAIT = 2 → sel/strobes go 0 asynchronously, no resp_valid; after release req_ready_out = 1 and fault_count = 0.
- Force 0xFFFF+2 faults → fault_count saturates at 0xFFFF.
